// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset main controller: one FSM state per clock, Moore outputs
// registered alongside the state; write enables are masked while reset is high.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       pcen,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  state_e     state_q, state_d;
  logic       iord_q, memwrite_q, irwrite_q, regdst_q, memtoreg_q, regwrite_q;
  logic       alusrca_q, pcwrite_q, branch_q;
  logic [1:0] alusrcb_q, pcsrc_q, aluop_q;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // Output registers are loaded with the decode of the state being entered,
  // so they always line up with state_q without a combinational decode stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      iord_q     <= 1'b0;
      memwrite_q <= 1'b0;
      irwrite_q  <= 1'b1;
      regdst_q   <= 1'b0;
      memtoreg_q <= 1'b0;
      regwrite_q <= 1'b0;
      alusrca_q  <= 1'b0;
      alusrcb_q  <= 2'b01;
      pcsrc_q    <= 2'b00;
      aluop_q    <= 2'b00;
      pcwrite_q  <= 1'b1;
      branch_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      iord_q     <= 1'b0;
      memwrite_q <= 1'b0;
      irwrite_q  <= 1'b0;
      regdst_q   <= 1'b0;
      memtoreg_q <= 1'b0;
      regwrite_q <= 1'b0;
      alusrca_q  <= 1'b0;
      alusrcb_q  <= 2'b00;
      pcsrc_q    <= 2'b00;
      aluop_q    <= 2'b00;
      pcwrite_q  <= 1'b0;
      branch_q   <= 1'b0;
      case (state_d)
        S_FETCH: begin
          alusrcb_q <= 2'b01;
          irwrite_q <= 1'b1;
          pcwrite_q <= 1'b1;
        end
        S_DECODE:  alusrcb_q <= 2'b11;
        S_MEMADR: begin
          alusrca_q <= 1'b1;
          alusrcb_q <= 2'b10;
        end
        S_MEMRD:   iord_q <= 1'b1;
        S_MEMWB: begin
          memtoreg_q <= 1'b1;
          regwrite_q <= 1'b1;
        end
        S_MEMWR: begin
          iord_q     <= 1'b1;
          memwrite_q <= 1'b1;
        end
        S_EXECUTE: begin
          alusrca_q <= 1'b1;
          aluop_q   <= 2'b10;
        end
        S_ALUWB: begin
          regdst_q   <= 1'b1;
          regwrite_q <= 1'b1;
        end
        S_BRANCH: begin
          alusrca_q <= 1'b1;
          aluop_q   <= 2'b01;
          pcsrc_q   <= 2'b01;
          branch_q  <= 1'b1;
        end
        S_ADDIEX: begin
          alusrca_q <= 1'b1;
          alusrcb_q <= 2'b10;
        end
        S_ADDIWB:  regwrite_q <= 1'b1;
        S_JUMP: begin
          pcsrc_q   <= 2'b10;
          pcwrite_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // funct is decoded live so EXECUTE follows the instruction register directly.
  always_comb begin
    alucontrol = 3'b010;
    case (aluop_q)
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

  assign iord     = iord_q;
  assign memwrite = memwrite_q & ~reset;
  assign irwrite  = irwrite_q & ~reset;
  assign regdst   = regdst_q;
  assign memtoreg = memtoreg_q;
  assign regwrite = regwrite_q & ~reset;
  assign alusrca  = alusrca_q;
  assign alusrcb  = alusrcb_q;
  assign pcsrc    = pcsrc_q;
  assign pcen     = (pcwrite_q | (branch_q & zero)) & ~reset;
  assign state    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed instructions from the test plan, then random ones,
// each cycle compared against an instruction-level reference model.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int n_vec = 0;
  int n_bad = 0;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .alucontrol(alucontrol), .pcen(pcen), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-state control word {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc}
  logic [10:0] ctl_tab [0:11];
  logic [1:0]  aluop_tab [0:11];
  initial begin
    ctl_tab[0]  = 11'b0010000_01_00;
    ctl_tab[1]  = 11'b0000000_11_00;
    ctl_tab[2]  = 11'b0000001_10_00;
    ctl_tab[3]  = 11'b1000000_00_00;
    ctl_tab[4]  = 11'b0000110_00_00;
    ctl_tab[5]  = 11'b1100000_00_00;
    ctl_tab[6]  = 11'b0000001_00_00;
    ctl_tab[7]  = 11'b0001010_00_00;
    ctl_tab[8]  = 11'b0000001_00_01;
    ctl_tab[9]  = 11'b0000001_10_00;
    ctl_tab[10] = 11'b0000010_00_00;
    ctl_tab[11] = 11'b0000000_00_10;
    for (int i = 0; i < 12; i++) aluop_tab[i] = 2'b00;
    aluop_tab[6] = 2'b10;
    aluop_tab[8] = 2'b01;
  end

  function automatic logic [2:0] alu_ref(input logic [1:0] aluop, input logic [5:0] f);
    if (aluop == 2'b01) return 3'b110;
    if (aluop != 2'b10) return 3'b010;
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic int seq_len(input logic [5:0] o);
    case (o)
      6'b100011: return 5;
      6'b101011, 6'b000000, 6'b001000: return 4;
      6'b000100, 6'b000010: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int seq_state(input logic [5:0] o, input int step);
    if (step < 2) return step;
    case (o)
      6'b100011: return (step == 2) ? 2 : (step == 3) ? 3 : 4;
      6'b101011: return (step == 2) ? 2 : 5;
      6'b000000: return (step == 2) ? 6 : 7;
      6'b001000: return (step == 2) ? 9 : 10;
      6'b000100: return 8;
      default:   return 11;
    endcase
  endfunction

  function automatic logic [10:0] got_ctl();
    return {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb, pcsrc};
  endfunction

  task automatic check_state(input string tag, input int s, input logic z);
    logic pcw, br;
    pcw = (s == 0) || (s == 11);
    br  = (s == 8);
    chk({tag, ".state"}, 32'(state), 32'(s));
    chk({tag, ".ctl"}, 32'(got_ctl()), 32'(ctl_tab[s]));
    chk({tag, ".alu"}, 32'(alucontrol), 32'(alu_ref(aluop_tab[s], funct)));
    chk({tag, ".pcen"}, 32'(pcen), 32'(pcw | (br & z)));
  endtask

  // Entered at a negedge with the FSM in FETCH; leaves at the next FETCH negedge.
  task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                           input int zmode);
    int n;
    n = seq_len(o);
    for (int step = 0; step < n; step++) begin
      op    = (step == 0) ? 6'($urandom) : o;
      funct = (step == 0) ? 6'($urandom) : f;
      zero  = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      #1;
      check_state(tag, seq_state(o, step), zero);
      @(negedge clk);
    end
  endtask

  logic [5:0] ops [0:6];

  initial begin
    ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000; ops[3] = 6'b000100;
    ops[4] = 6'b001000; ops[5] = 6'b000010; ops[6] = 6'b111111;
    reset = 1'b1; op = 6'b100011; funct = 6'b0; zero = 1'b0;
    #2;
    chk("rst.state", 32'(state), 32'd0);
    chk("rst.enables", 32'({pcen, irwrite, memwrite, regwrite}), 32'd0);
    chk("rst.alusrcb", 32'(alusrcb), 32'b01);
    @(negedge clk);
    reset = 1'b0;

    run_instr("lw", 6'b100011, 6'b0, 0);
    run_instr("slt", 6'b000000, 6'b101010, 0);
    run_instr("beq_t", 6'b000100, 6'b0, 1);
    run_instr("beq_n", 6'b000100, 6'b0, 0);
    run_instr("sw", 6'b101011, 6'b0, 2);
    run_instr("addi", 6'b001000, 6'b0, 2);
    run_instr("j", 6'b000010, 6'b0, 2);
    run_instr("ill", 6'b111111, 6'b0, 2);
    run_instr("rbad", 6'b000000, 6'b000111, 2);

    // Reset mid-MEMRD of a load
    op = 6'b100011;
    repeat (3) @(negedge clk);
    #1;
    chk("mid.pre", 32'(state), 32'd3);
    #1 reset = 1'b1;
    #1;
    chk("mid.state", 32'(state), 32'd0);
    chk("mid.enables", 32'({pcen, irwrite, memwrite, regwrite}), 32'd0);
    @(posedge clk); #1;
    chk("mid.hold", 32'(state), 32'd0);
    chk("mid.hold_en", 32'({pcen, irwrite, memwrite, regwrite}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_state("mid.rel", 0, zero);
    @(negedge clk); #1;
    chk("mid.next", 32'(state), 32'd1);
    op = 6'b111111;
    @(negedge clk);

    for (int k = 0; k < 200; k++) begin
      logic [5:0] o, f;
      o = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
      f = ($urandom_range(0, 1) == 0) ? 6'($urandom) :
          ((k % 5 == 0) ? 6'b100000 : (k % 5 == 1) ? 6'b100010 :
           (k % 5 == 2) ? 6'b100100 : (k % 5 == 3) ? 6'b100101 : 6'b101010);
      run_instr("rnd", o, f, 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
